// File: rtl/ahb_master_pkg.sv
// Shared encodings, state enum and helpers for the AHB-Lite master wrapper.
// Used by ahb_master_wrapper (optional feature macro: AHB_ERROR_RESP_EN).
package ahb_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  // A beat landing on a 1KB-aligned address must restart the burst as NONSEQ.
  function automatic logic at_1kb_start(input logic [9:0] addr_lo);
    return addr_lo == 10'd0;
  endfunction

endpackage

// File: rtl/ahb_master_wrapper.sv
// AHB-Lite master turning eFPGA core request/valid handshakes into single or INCR word transfers.
// Define AHB_ERROR_RESP_EN to abort on an ERROR response; otherwise HRESP is ignored.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no transfer outstanding, waiting for writereq/readreq
// ST_ADDR | address phase on the bus (a previous data phase may overlap)
// ST_DATA | last data phase pending, no new address issued
module ahb_master_wrapper
  import ahb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic                  HSEL,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic [1:0]            HRESP,
  input  logic                  HREADY,
  input  logic [ADDR_WIDTH-1:0] TARGET_ADDRESS,
  input  logic [DATA_WIDTH-1:0] eflx_rdata,
  input  logic                  writereq,
  input  logic                  readreq,
  output logic                  eflx_rvalid_data,
  output logic                  eflx_wvalid_data,
  output logic [DATA_WIDTH-1:0] eflx_wdata
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] haddr_d, next_addr;
  logic [1:0]            htrans_d;
  logic                  hwrite_d, hsel_d;
  logic [DATA_WIDTH-1:0] hwdata_d, wdata_d;
  logic                  rvalid_d, wvalid_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic                  same_req, opp_req;

`ifndef AHB_ERROR_RESP_EN
  logic unused_hresp;
  assign unused_hresp = ^HRESP;
`endif

  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_INCR;

  always_comb begin
    state_d    = state_q;
    haddr_d    = HADDR;
    htrans_d   = HTRANS;
    hwrite_d   = HWRITE;
    hsel_d     = HSEL;
    hwdata_d   = HWDATA;
    wdata_d    = eflx_wdata;
    rvalid_d   = 1'b0;
    wvalid_d   = 1'b0;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    next_addr  = HADDR + ADDR_WIDTH'(4);
    same_req   = HWRITE ? writereq : readreq;
    opp_req    = HWRITE ? readreq : writereq;

    unique case (state_q)
      ST_IDLE: begin
        if (writereq || readreq) begin
          state_d    = ST_ADDR;
          haddr_d    = TARGET_ADDRESS;
          hwrite_d   = writereq;
          htrans_d   = HTRANS_NONSEQ;
          hsel_d     = 1'b1;
          dp_valid_d = 1'b0;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          // HREADY completes the overlapped data phase and accepts the current address together.
          if (dp_valid_q && !dp_write_q) begin
            wdata_d  = HRDATA;
            wvalid_d = 1'b1;
          end
          if (HWRITE) begin
            hwdata_d = eflx_rdata;
            rvalid_d = 1'b1;
          end
          dp_valid_d = 1'b1;
          dp_write_d = HWRITE;
          if (same_req && !opp_req) begin
            haddr_d  = next_addr;
            htrans_d = at_1kb_start(next_addr[9:0]) ? HTRANS_NONSEQ : HTRANS_SEQ;
          end else begin
            htrans_d = HTRANS_IDLE;
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          if (!dp_write_q) begin
            wdata_d  = HRDATA;
            wvalid_d = 1'b1;
          end
          dp_valid_d = 1'b0;
          hsel_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef AHB_ERROR_RESP_EN
    if (dp_valid_q && (HRESP == HRESP_ERROR)) begin
      state_d    = ST_IDLE;
      htrans_d   = HTRANS_IDLE;
      hsel_d     = 1'b0;
      dp_valid_d = 1'b0;
      rvalid_d   = 1'b0;
      wvalid_d   = 1'b0;
      wdata_d    = eflx_wdata;
      hwdata_d   = HWDATA;
    end
`endif
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q          <= ST_IDLE;
      HADDR            <= '0;
      HTRANS           <= HTRANS_IDLE;
      HWRITE           <= 1'b0;
      HSEL             <= 1'b0;
      HWDATA           <= '0;
      eflx_wdata       <= '0;
      eflx_rvalid_data <= 1'b0;
      eflx_wvalid_data <= 1'b0;
      dp_valid_q       <= 1'b0;
      dp_write_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      HADDR            <= haddr_d;
      HTRANS           <= htrans_d;
      HWRITE           <= hwrite_d;
      HSEL             <= hsel_d;
      HWDATA           <= hwdata_d;
      eflx_wdata       <= wdata_d;
      eflx_rvalid_data <= rvalid_d;
      eflx_wvalid_data <= wvalid_d;
      dp_valid_q       <= dp_valid_d;
      dp_write_q       <= dp_write_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_wrapper.sv
// Directed bench for ahb_master_wrapper: single/burst transfers, 1KB boundary, priority, reset, HRESP.
// Exercises the AHB_ERROR_RESP_EN abort path when that macro is defined.
module tb_ahb_master_wrapper;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic        HSEL;
  logic [31:0] HWDATA, HRDATA;
  logic [1:0]  HRESP;
  logic        HREADY;
  logic [31:0] TARGET_ADDRESS, eflx_rdata;
  logic        writereq, readreq;
  logic        eflx_rvalid_data, eflx_wvalid_data;
  logic [31:0] eflx_wdata;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_master_wrapper #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HSEL(HSEL), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HRESP(HRESP), .HREADY(HREADY), .TARGET_ADDRESS(TARGET_ADDRESS), .eflx_rdata(eflx_rdata),
    .writereq(writereq), .readreq(readreq), .eflx_rvalid_data(eflx_rvalid_data),
    .eflx_wvalid_data(eflx_wvalid_data), .eflx_wdata(eflx_wdata)
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; writereq = 1'b0; readreq = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
    HRDATA = 32'h0; TARGET_ADDRESS = 32'h0; eflx_rdata = 32'h0;
    step(); step();
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSEL, HWDATA, eflx_wdata, eflx_rvalid_data, eflx_wvalid_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got htrans=%h haddr=%h hwrite=%b hsel=%b hwdata=%h wdata=%h rv=%b wv=%b exp all zero",
               HTRANS, HADDR, HWRITE, HSEL, HWDATA, eflx_wdata, eflx_rvalid_data, eflx_wvalid_data);
    end
    checks++;
    if ({HSIZE, HBURST} !== 6'b010_001) begin
      errors++;
      $display("FAIL reset_size_burst got %b_%b exp 010_001", HSIZE, HBURST);
    end
    HRESET = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    TARGET_ADDRESS = 32'hA000_0000; eflx_rdata = 32'h1111_2222; writereq = 1'b1; HREADY = 1'b0;
    step();
    writereq = 1'b0; TARGET_ADDRESS = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({HTRANS, HADDR, HWRITE, HSEL, eflx_rvalid_data} !== {2'b10, 32'hA000_0000, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL sw_addr_hold%0d got htrans=%h haddr=%h hwrite=%b hsel=%b rv=%b exp 2/a0000000/1/1/0",
                 i, HTRANS, HADDR, HWRITE, HSEL, eflx_rvalid_data);
      end
      if (i < 2) step();
    end
    HREADY = 1'b1;
    step();
    eflx_rdata = 32'h9999_9999;
    checks++;
    if ({HTRANS, HSEL, HWDATA, eflx_rvalid_data} !== {2'b00, 1'b1, 32'h1111_2222, 1'b1}) begin
      errors++;
      $display("FAIL sw_data_phase got htrans=%h hsel=%b hwdata=%h rv=%b exp 0/1/11112222/1",
               HTRANS, HSEL, HWDATA, eflx_rvalid_data);
    end
    step();
    checks++;
    if ({HSEL, HWDATA, eflx_rvalid_data} !== {1'b0, 32'h1111_2222, 1'b0}) begin
      errors++;
      $display("FAIL sw_done got hsel=%b hwdata=%h rv=%b exp 0/11112222/0", HSEL, HWDATA, eflx_rvalid_data);
    end
  endtask

  task automatic test_single_read();
    TARGET_ADDRESS = 32'hB000_0000; readreq = 1'b1; HREADY = 1'b0; HRDATA = 32'hDEAD_BEEF;
    step();
    readreq = 1'b0; TARGET_ADDRESS = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({HTRANS, HADDR, HWRITE, HSEL, eflx_wvalid_data} !== {2'b10, 32'hB000_0000, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL sr_addr_hold%0d got htrans=%h haddr=%h hwrite=%b hsel=%b wv=%b exp 2/b0000000/0/1/0",
                 i, HTRANS, HADDR, HWRITE, HSEL, eflx_wvalid_data);
      end
      if (i < 3) step();
    end
    HREADY = 1'b1;
    step();
    checks++;
    if ({HTRANS, HSEL, eflx_wvalid_data} !== {2'b00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sr_accept got htrans=%h hsel=%b wv=%b exp 0/1/0", HTRANS, HSEL, eflx_wvalid_data);
    end
    HRDATA = 32'h5;
    step();
    checks++;
    if ({eflx_wdata, eflx_wvalid_data, HSEL} !== {32'h5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sr_data got wdata=%h wv=%b hsel=%b exp 5/1/0", eflx_wdata, eflx_wvalid_data, HSEL);
    end
    HRDATA = 32'h7;
    step();
    checks++;
    if ({eflx_wdata, eflx_wvalid_data} !== {32'h5, 1'b0}) begin
      errors++;
      $display("FAIL sr_pulse_end got wdata=%h wv=%b exp 5/0", eflx_wdata, eflx_wvalid_data);
    end
  endtask

  task automatic test_write_burst();
    logic [31:0] exp_addr;
    logic [1:0]  exp_trans;
    int          rv_cnt;
    rv_cnt = 0;
    TARGET_ADDRESS = 32'hC000_0000; writereq = 1'b1; HREADY = 1'b1;
    for (int i = 0; i < 13; i++) begin
      eflx_rdata = 32'h100 + i;
      step();
      TARGET_ADDRESS = 32'h0;
      exp_addr  = 32'hC000_0000 + 32'(4 * i);
      exp_trans = (i == 0) ? 2'b10 : 2'b11;
      if (eflx_rvalid_data) rv_cnt++;
      checks++;
      if ({HTRANS, HADDR, HSEL, eflx_rvalid_data} !== {exp_trans, exp_addr, 1'b1, (i > 0)}) begin
        errors++;
        $display("FAIL wb_beat%0d got htrans=%h haddr=%h hsel=%b rv=%b exp %h/%h/1/%b",
                 i, HTRANS, HADDR, HSEL, eflx_rvalid_data, exp_trans, exp_addr, (i > 0));
      end
      if (i > 0) begin
        checks++;
        if (HWDATA !== 32'h100 + i) begin
          errors++;
          $display("FAIL wb_hwdata%0d got %h exp %h", i, HWDATA, 32'h100 + i);
        end
      end
    end
    writereq = 1'b0; eflx_rdata = 32'h10D;
    step();
    if (eflx_rvalid_data) rv_cnt++;
    checks++;
    if ({HTRANS, HADDR, HSEL, HWDATA, eflx_rvalid_data} !== {2'b00, 32'hC000_0030, 1'b1, 32'h10D, 1'b1}) begin
      errors++;
      $display("FAIL wb_last got htrans=%h haddr=%h hsel=%b hwdata=%h rv=%b exp 0/c0000030/1/10d/1",
               HTRANS, HADDR, HSEL, HWDATA, eflx_rvalid_data);
    end
    step();
    if (eflx_rvalid_data) rv_cnt++;
    checks++;
    if ({HSEL, eflx_rvalid_data} !== 2'b00) begin
      errors++;
      $display("FAIL wb_done got hsel=%b rv=%b exp 0/0", HSEL, eflx_rvalid_data);
    end
    checks++;
    if (rv_cnt != 13) begin
      errors++;
      $display("FAIL wb_pulse_count got %0d exp 13", rv_cnt);
    end
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_addr;
    logic [1:0]  exp_trans;
    int          wv_cnt;
    wv_cnt = 0;
    TARGET_ADDRESS = 32'hD000_0000; HREADY = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      readreq = (e <= 6);
      HRDATA  = 32'h50 + e;
      step();
      TARGET_ADDRESS = 32'h0;
      exp_trans = (e == 1) ? 2'b10 : ((e <= 6) ? 2'b11 : 2'b00);
      exp_addr  = (e <= 6) ? 32'hD000_0000 + 32'(4 * (e - 1)) : 32'hD000_0014;
      if (eflx_wvalid_data) wv_cnt++;
      checks++;
      if ({HTRANS, HADDR, HSEL, eflx_wvalid_data} !== {exp_trans, exp_addr, (e <= 7), (e >= 3)}) begin
        errors++;
        $display("FAIL rb_edge%0d got htrans=%h haddr=%h hsel=%b wv=%b exp %h/%h/%b/%b",
                 e, HTRANS, HADDR, HSEL, eflx_wvalid_data, exp_trans, exp_addr, (e <= 7), (e >= 3));
      end
      if (e >= 3) begin
        checks++;
        if (eflx_wdata !== 32'h50 + e) begin
          errors++;
          $display("FAIL rb_wdata%0d got %h exp %h", e, eflx_wdata, 32'h50 + e);
        end
      end
    end
    checks++;
    if (wv_cnt != 6) begin
      errors++;
      $display("FAIL rb_pulse_count got %0d exp 6", wv_cnt);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] exp_addr [4];
    logic [1:0]  exp_trans [4];
    exp_addr  = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
    exp_trans = '{2'b10, 2'b11, 2'b10, 2'b11};
    TARGET_ADDRESS = 32'h0000_03F8; writereq = 1'b1; HREADY = 1'b1; eflx_rdata = 32'hAB;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({HTRANS, HADDR} !== {exp_trans[i], exp_addr[i]}) begin
        errors++;
        $display("FAIL bnd_beat%0d got htrans=%h haddr=%h exp %h/%h",
                 i, HTRANS, HADDR, exp_trans[i], exp_addr[i]);
      end
    end
    writereq = 1'b0;
    step();
    step();
    checks++;
    if ({HTRANS, HSEL} !== 3'b000) begin
      errors++;
      $display("FAIL bnd_done got htrans=%h hsel=%b exp 0/0", HTRANS, HSEL);
    end
  endtask

  task automatic test_direction_switch();
    TARGET_ADDRESS = 32'h4000; writereq = 1'b1; HREADY = 1'b1; eflx_rdata = 32'hC0DE;
    step();
    readreq = 1'b1;
    step();
    checks++;
    if ({HTRANS, HSEL, eflx_rvalid_data} !== {2'b00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL dir_end_burst got htrans=%h hsel=%b rv=%b exp 0/1/1", HTRANS, HSEL, eflx_rvalid_data);
    end
    writereq = 1'b0; TARGET_ADDRESS = 32'h4100;
    step();
    step();
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSEL} !== {2'b10, 32'h4100, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL dir_read_start got htrans=%h haddr=%h hwrite=%b hsel=%b exp 2/4100/0/1",
               HTRANS, HADDR, HWRITE, HSEL);
    end
    readreq = 1'b0; HRDATA = 32'h1234;
    step();
    step();
    checks++;
    if ({eflx_wdata, eflx_wvalid_data, HSEL} !== {32'h1234, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dir_read_data got wdata=%h wv=%b hsel=%b exp 1234/1/0", eflx_wdata, eflx_wvalid_data, HSEL);
    end
  endtask

  task automatic test_priority();
    TARGET_ADDRESS = 32'h3000; writereq = 1'b1; readreq = 1'b1; HREADY = 1'b1;
    step();
    writereq = 1'b0; readreq = 1'b0;
    checks++;
    if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h3000, 1'b1}) begin
      errors++;
      $display("FAIL prio_write_wins got htrans=%h haddr=%h hwrite=%b exp 2/3000/1", HTRANS, HADDR, HWRITE);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid_burst();
    TARGET_ADDRESS = 32'h2000; writereq = 1'b1; HREADY = 1'b1; eflx_rdata = 32'h55AA;
    step(); step(); step();
    checks++;
    if ({HTRANS, eflx_rvalid_data} !== {2'b11, 1'b1}) begin
      errors++;
      $display("FAIL rst_pre_burst got htrans=%h rv=%b exp 3/1", HTRANS, eflx_rvalid_data);
    end
    HRESET = 1'b1;
    step();
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSEL, HWDATA, eflx_wdata, eflx_rvalid_data, eflx_wvalid_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid_burst got htrans=%h haddr=%h hwrite=%b hsel=%b hwdata=%h wdata=%h rv=%b wv=%b exp all zero",
               HTRANS, HADDR, HWRITE, HSEL, HWDATA, eflx_wdata, eflx_rvalid_data, eflx_wvalid_data);
    end
    HRESET = 1'b0; writereq = 1'b0;
    step();
    checks++;
    if ({HTRANS, HSEL, eflx_rvalid_data} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_after got htrans=%h hsel=%b rv=%b exp 0/0/0", HTRANS, HSEL, eflx_rvalid_data);
    end
  endtask

  task automatic test_hresp();
    TARGET_ADDRESS = 32'h5000; readreq = 1'b1; HREADY = 1'b1; HRDATA = 32'h77; HRESP = 2'b00;
    step();
    step();
    readreq = 1'b0;
`ifdef AHB_ERROR_RESP_EN
    HRESP = 2'b01; HREADY = 1'b0;
    step();
    checks++;
    if ({HTRANS, HSEL, eflx_wvalid_data} !== {2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL err_abort got htrans=%h hsel=%b wv=%b exp 0/0/0", HTRANS, HSEL, eflx_wvalid_data);
    end
    HRESP = 2'b00; HREADY = 1'b1;
    step();
    checks++;
    if ({HTRANS, HSEL, eflx_wvalid_data} !== {2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL err_dropped got htrans=%h hsel=%b wv=%b exp 0/0/0", HTRANS, HSEL, eflx_wvalid_data);
    end
`else
    HRESP = 2'b01;
    step();
    checks++;
    if ({eflx_wdata, eflx_wvalid_data, HSEL} !== {32'h77, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL hresp_ignored got wdata=%h wv=%b hsel=%b exp 77/1/1", eflx_wdata, eflx_wvalid_data, HSEL);
    end
    HRESP = 2'b00; HRDATA = 32'h78;
    step();
    checks++;
    if ({eflx_wdata, eflx_wvalid_data, HSEL} !== {32'h78, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL hresp_last_beat got wdata=%h wv=%b hsel=%b exp 78/1/0", eflx_wdata, eflx_wvalid_data, HSEL);
    end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_write_burst();
    test_read_burst();
    test_boundary();
    test_direction_switch();
    test_priority();
    test_reset_mid_burst();
    test_hresp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
